// File: rtl/debug_creg_sequencer.sv
// Debugger access sequencer for the shared creg port. Debugger accesses go into
// idle pipeline slots, and a stall is requested when the pipeline starves them.
module debug_creg_sequencer #(
  parameter int unsigned THREAD_IDX_WIDTH = 2,
  parameter int unsigned CREG_INDEX_WIDTH = 5,
  parameter int unsigned STARVE_LIMIT     = 15
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        ocd_creg_req,
  input  logic                        ocd_creg_write,
  input  logic [THREAD_IDX_WIDTH-1:0] ocd_creg_thread,
  input  logic [CREG_INDEX_WIDTH-1:0] ocd_creg_index,
  input  logic [31:0]                 ocd_creg_wdata,
  output logic                        dbg_creg_busy,
  output logic                        dbg_creg_ack,
  output logic [31:0]                 dbg_creg_rdata,
  output logic                        dbg_creg_overrun,
  input  logic                        pipe_creg_active,
  output logic                        dbg_pipe_stall,
  output logic                        dbg_creg_read_en,
  output logic                        dbg_creg_write_en,
  output logic [THREAD_IDX_WIDTH-1:0] dbg_creg_thread,
  output logic [CREG_INDEX_WIDTH-1:0] dbg_creg_index,
  output logic [31:0]                 dbg_creg_wdata,
  input  logic [31:0]                 cr_creg_read_val
);

  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {StIdle, StWaitSlot, StCapture} state_e;

  state_e                      state_q, state_d;
  logic                        write_q, write_d;
  logic [THREAD_IDX_WIDTH-1:0] thread_q, thread_d;
  logic [CREG_INDEX_WIDTH-1:0] index_q, index_d;
  logic [31:0]                 wdata_q, wdata_d;
  logic [31:0]                 rdata_q, rdata_d;
  logic [CntW-1:0]             starve_q, starve_d;
  logic                        ack_q, ack_d;
  logic                        overrun_q, overrun_d;
  logic                        grant;

  assign grant = !pipe_creg_active;

  always_comb begin
    state_d           = state_q;
    write_d           = write_q;
    thread_d          = thread_q;
    index_d           = index_q;
    wdata_d           = wdata_q;
    rdata_d           = rdata_q;
    starve_d          = starve_q;
    ack_d             = 1'b0;
    overrun_d         = overrun_q;
    dbg_creg_read_en  = 1'b0;
    dbg_creg_write_en = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ocd_creg_req) begin
          write_d   = ocd_creg_write;
          thread_d  = ocd_creg_thread;
          index_d   = ocd_creg_index;
          wdata_d   = ocd_creg_wdata;
          starve_d  = '0;
          overrun_d = 1'b0;
          state_d   = StWaitSlot;
        end
      end
      StWaitSlot: begin
        if (ocd_creg_req) overrun_d = 1'b1;
        if (grant) begin
          dbg_creg_write_en = write_q;
          dbg_creg_read_en  = !write_q;
          state_d           = StCapture;
        end else if (starve_q != CntW'(STARVE_LIMIT)) begin
          starve_d = starve_q + CntW'(1);
        end
      end
      StCapture: begin
        if (ocd_creg_req) overrun_d = 1'b1;
        // Read data is registered in the creg file, so it arrives one cycle after the strobe.
        if (!write_q) rdata_d = cr_creg_read_val;
        ack_d   = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      write_q   <= 1'b0;
      thread_q  <= '0;
      index_q   <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      starve_q  <= '0;
      ack_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      write_q   <= write_d;
      thread_q  <= thread_d;
      index_q   <= index_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      starve_q  <= starve_d;
      ack_q     <= ack_d;
      overrun_q <= overrun_d;
    end
  end

  assign dbg_creg_busy    = (state_q != StIdle);
  assign dbg_creg_ack     = ack_q;
  assign dbg_creg_rdata   = rdata_q;
  assign dbg_creg_overrun = overrun_q;
  assign dbg_creg_thread  = thread_q;
  assign dbg_creg_index   = index_q;
  assign dbg_creg_wdata   = wdata_q;
  assign dbg_pipe_stall   = (state_q == StWaitSlot) && (starve_q == CntW'(STARVE_LIMIT));

  a_strobe_onehot : assert property (@(posedge clk) disable iff (reset)
    !(dbg_creg_read_en && dbg_creg_write_en));
  a_no_port_clash : assert property (@(posedge clk) disable iff (reset)
    !((dbg_creg_read_en || dbg_creg_write_en) && pipe_creg_active));
  a_stall_honoured : assert property (@(posedge clk) disable iff (reset)
    dbg_pipe_stall |=> !pipe_creg_active);

endmodule

// File: tb/tb_debug_creg_sequencer.sv
// Directed bench for debug_creg_sequencer: read/write, blocking, starvation stall,
// overrun and mid-operation reset, with hand-computed cycle-exact expectations.
module tb_debug_creg_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        ocd_creg_req, ocd_creg_write;
  logic [1:0]  ocd_creg_thread;
  logic [4:0]  ocd_creg_index;
  logic [31:0] ocd_creg_wdata;
  logic        dbg_creg_busy, dbg_creg_ack, dbg_creg_overrun;
  logic [31:0] dbg_creg_rdata;
  logic        pipe_creg_active, dbg_pipe_stall;
  logic        dbg_creg_read_en, dbg_creg_write_en;
  logic [1:0]  dbg_creg_thread;
  logic [4:0]  dbg_creg_index;
  logic [31:0] dbg_creg_wdata;
  logic [31:0] cr_creg_read_val;

  int checks = 0;
  int failures = 0;
  int acks;

  debug_creg_sequencer #(
    .THREAD_IDX_WIDTH(2),
    .CREG_INDEX_WIDTH(5),
    .STARVE_LIMIT(15)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .ocd_creg_req     (ocd_creg_req),
    .ocd_creg_write   (ocd_creg_write),
    .ocd_creg_thread  (ocd_creg_thread),
    .ocd_creg_index   (ocd_creg_index),
    .ocd_creg_wdata   (ocd_creg_wdata),
    .dbg_creg_busy    (dbg_creg_busy),
    .dbg_creg_ack     (dbg_creg_ack),
    .dbg_creg_rdata   (dbg_creg_rdata),
    .dbg_creg_overrun (dbg_creg_overrun),
    .pipe_creg_active (pipe_creg_active),
    .dbg_pipe_stall   (dbg_pipe_stall),
    .dbg_creg_read_en (dbg_creg_read_en),
    .dbg_creg_write_en(dbg_creg_write_en),
    .dbg_creg_thread  (dbg_creg_thread),
    .dbg_creg_index   (dbg_creg_index),
    .dbg_creg_wdata   (dbg_creg_wdata),
    .cr_creg_read_val (cr_creg_read_val)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Move to the next cycle (just after the edge), where inputs are driven.
  task automatic cyc();
    @(posedge clk);
    #1;
    ocd_creg_req = 1'b0;
  endtask

  // Sample point within the current cycle.
  task automatic mid();
    @(negedge clk);
  endtask

  task automatic issue(input logic wr, input logic [1:0] th, input logic [4:0] idx,
                       input logic [31:0] wd);
    ocd_creg_req    = 1'b1;
    ocd_creg_write  = wr;
    ocd_creg_thread = th;
    ocd_creg_index  = idx;
    ocd_creg_wdata  = wd;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_busy"}, 32'(dbg_creg_busy), 0);
    check_eq({tag, "_ack"}, 32'(dbg_creg_ack), 0);
    check_eq({tag, "_rdata"}, dbg_creg_rdata, 0);
    check_eq({tag, "_ovr"}, 32'(dbg_creg_overrun), 0);
    check_eq({tag, "_stall"}, 32'(dbg_pipe_stall), 0);
    check_eq({tag, "_strobes"}, {30'd0, dbg_creg_read_en, dbg_creg_write_en}, 0);
    check_eq({tag, "_fields"}, {25'd0, dbg_creg_thread, dbg_creg_index}, 0);
    check_eq({tag, "_wdata"}, dbg_creg_wdata, 0);
  endtask

  initial begin
    reset = 1'b1;
    ocd_creg_req = 1'b0; ocd_creg_write = 1'b0; ocd_creg_thread = '0;
    ocd_creg_index = '0; ocd_creg_wdata = '0;
    pipe_creg_active = 1'b0;
    cr_creg_read_val = 32'hffff_ffff;
    cyc(); cyc();
    mid();
    check_idle_outputs("rst");
    cyc();
    reset = 1'b0;
    cyc();

    // Read with pipeline idle; req at N.
    issue(1'b0, 2'd2, 5'd5, 32'h0);
    mid(); check_eq("rd_n_busy", 32'(dbg_creg_busy), 0);
    cyc(); mid();                                   // N+1
    check_eq("rd_n1_ren", 32'(dbg_creg_read_en), 1);
    check_eq("rd_n1_wen", 32'(dbg_creg_write_en), 0);
    check_eq("rd_n1_busy", 32'(dbg_creg_busy), 1);
    check_eq("rd_n1_thread", 32'(dbg_creg_thread), 2);
    check_eq("rd_n1_index", 32'(dbg_creg_index), 5);
    cyc(); cr_creg_read_val = 32'h1234_5678; mid(); // N+2
    check_eq("rd_n2_ren", 32'(dbg_creg_read_en), 0);
    check_eq("rd_n2_busy", 32'(dbg_creg_busy), 1);
    check_eq("rd_n2_ack", 32'(dbg_creg_ack), 0);
    cyc(); cr_creg_read_val = 32'hffff_ffff; mid(); // N+3
    check_eq("rd_n3_ack", 32'(dbg_creg_ack), 1);
    check_eq("rd_n3_rdata", dbg_creg_rdata, 32'h1234_5678);
    check_eq("rd_n3_busy", 32'(dbg_creg_busy), 0);
    cyc(); mid();                                   // N+4
    check_eq("rd_n4_ack", 32'(dbg_creg_ack), 0);
    check_eq("rd_n4_rdata", dbg_creg_rdata, 32'h1234_5678);

    // Write with pipeline idle.
    cyc(); issue(1'b1, 2'd1, 5'd13, 32'hDEAD_BEEF);
    cyc(); mid();                                   // N+1
    check_eq("wr_n1_wen", 32'(dbg_creg_write_en), 1);
    check_eq("wr_n1_ren", 32'(dbg_creg_read_en), 0);
    check_eq("wr_n1_thread", 32'(dbg_creg_thread), 1);
    check_eq("wr_n1_index", 32'(dbg_creg_index), 13);
    check_eq("wr_n1_wdata", dbg_creg_wdata, 32'hDEAD_BEEF);
    cyc(); mid();                                   // N+2
    check_eq("wr_n2_wen", 32'(dbg_creg_write_en), 0);
    cyc(); mid();                                   // N+3
    check_eq("wr_n3_ack", 32'(dbg_creg_ack), 1);
    check_eq("wr_n3_rdata", dbg_creg_rdata, 32'h1234_5678);

    // Pipeline blocks three cycles.
    cyc(); issue(1'b0, 2'd3, 5'd1, 32'h0);
    for (int k = 1; k <= 3; k++) begin
      cyc(); pipe_creg_active = 1'b1; mid();
      check_eq($sformatf("blk_n%0d_ren", k), 32'(dbg_creg_read_en), 0);
      check_eq($sformatf("blk_n%0d_stall", k), 32'(dbg_pipe_stall), 0);
    end
    cyc(); pipe_creg_active = 1'b0; mid();          // N+4
    check_eq("blk_n4_ren", 32'(dbg_creg_read_en), 1);
    cyc(); mid();                                   // N+5
    check_eq("blk_n5_ack", 32'(dbg_creg_ack), 0);
    cyc(); mid();                                   // N+6
    check_eq("blk_n6_ack", 32'(dbg_creg_ack), 1);
    check_eq("blk_n6_rdata", dbg_creg_rdata, 32'hffff_ffff);

    // Starvation: pipeline active until the stall is seen.
    cyc(); issue(1'b1, 2'd0, 5'd31, 32'h0000_00A5);
    for (int k = 1; k <= 16; k++) begin
      cyc(); pipe_creg_active = 1'b1; mid();
      check_eq($sformatf("stv_n%0d_stall", k), 32'(dbg_pipe_stall), (k == 16) ? 1 : 0);
      check_eq($sformatf("stv_n%0d_wen", k), 32'(dbg_creg_write_en), 0);
    end
    cyc(); pipe_creg_active = 1'b0; mid();          // N+17
    check_eq("stv_n17_wen", 32'(dbg_creg_write_en), 1);
    check_eq("stv_n17_stall", 32'(dbg_pipe_stall), 1);
    cyc(); mid();                                   // N+18
    check_eq("stv_n18_stall", 32'(dbg_pipe_stall), 0);
    check_eq("stv_n18_busy", 32'(dbg_creg_busy), 1);
    cyc(); mid();                                   // N+19
    check_eq("stv_n19_ack", 32'(dbg_creg_ack), 1);

    // Overrun: second request one cycle later is dropped.
    cyc(); issue(1'b0, 2'd1, 5'd2, 32'h0);
    acks = 0;
    cyc(); issue(1'b1, 2'd3, 5'd7, 32'h5555_5555);
    check_eq("ovr_n1_thread", 32'(dbg_creg_thread), 1);
    for (int k = 1; k <= 6; k++) begin
      mid();
      if (dbg_creg_ack) acks++;
      if (k == 2) check_eq("ovr_n2_flag", 32'(dbg_creg_overrun), 1);
      if (k == 3) check_eq("ovr_n3_wen_none", 32'(dbg_creg_write_en), 0);
      cyc();
    end
    check_eq("ovr_ack_count", acks, 1);
    check_eq("ovr_sticky", 32'(dbg_creg_overrun), 1);
    issue(1'b0, 2'd0, 5'd3, 32'h0);
    cyc(); mid();
    check_eq("ovr_cleared", 32'(dbg_creg_overrun), 0);
    cyc(); cyc(); cyc();

    // Reset while in WAIT_SLOT.
    issue(1'b1, 2'd2, 5'd9, 32'hCAFE_F00D);
    cyc(); pipe_creg_active = 1'b1;                 // N+1, blocked
    cyc(); reset = 1'b1;                            // N+2, reset sampled
    mid(); check_eq("rsw_n2_busy", 32'(dbg_creg_busy), 1);
    cyc(); reset = 1'b0; pipe_creg_active = 1'b0; mid();
    check_idle_outputs("rsw");
    acks = 0;
    for (int k = 0; k < 3; k++) begin
      cyc(); mid();
      if (dbg_creg_ack) acks++;
    end
    check_eq("rsw_no_ack", acks, 0);
    cyc(); issue(1'b0, 2'd2, 5'd4, 32'h0);
    cyc(); mid();
    check_eq("rsw_new_ren", 32'(dbg_creg_read_en), 1);
    check_eq("rsw_new_index", 32'(dbg_creg_index), 4);
    cyc(); cr_creg_read_val = 32'h0BAD_CAFE;
    cyc(); cr_creg_read_val = 32'hffff_ffff; mid();
    check_eq("rsw_new_ack", 32'(dbg_creg_ack), 1);
    check_eq("rsw_new_rdata", dbg_creg_rdata, 32'h0BAD_CAFE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
